// File: rtl/rram_route_pkg.sv
// Shared types and helpers for the RRAM cluster router.
// Optional feature macro: RRAM_ROUTE_TAG_EN (adds source-core tag to output words).
package rram_route_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } inst_state_e;

    // ceil(log2(n)), but never less than one bit so single-core builds still have a cid field
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

    localparam int unsigned DEF_NUM_CORE      = 4;
    localparam int unsigned DEF_INSTR_WIDTH   = 4;
    localparam int unsigned DEF_OPCODE_WIDTH  = 16;
    localparam int unsigned DEF_DATAOUT_WIDTH = 64;
    localparam int unsigned DEF_CID_W         = clog2_min1(DEF_NUM_CORE);

    // Instruction FIFO word layout for the default configuration, MSB first
    typedef struct packed {
        logic                        bcast;
        logic [DEF_CID_W-1:0]        cid;
        logic [DEF_INSTR_WIDTH-1:0]  instr;
        logic [DEF_OPCODE_WIDTH-1:0] opcode;
    } inst_word_t;

endpackage

// File: rtl/rram_cluster_router_if.sv
// Host FIFO and per-core handshake bundle for the RRAM cluster router.
// Optional feature macro: RRAM_ROUTE_TAG_EN (widens din_oFIFO by the cid width).
interface rram_cluster_router_if import rram_route_pkg::*; #(
    parameter int unsigned NUM_CORE      = DEF_NUM_CORE,
    parameter int unsigned INSTR_WIDTH   = DEF_INSTR_WIDTH,
    parameter int unsigned OPCODE_WIDTH  = DEF_OPCODE_WIDTH,
    parameter int unsigned DATAOUT_WIDTH = DEF_DATAOUT_WIDTH
) ();

    localparam int unsigned CID_W = clog2_min1(NUM_CORE);
    localparam int unsigned IW    = INSTR_WIDTH + OPCODE_WIDTH;
`ifdef RRAM_ROUTE_TAG_EN
    localparam int unsigned OW    = DATAOUT_WIDTH + CID_W;
`else
    localparam int unsigned OW    = DATAOUT_WIDTH;
`endif

    logic                              pop_n_instFIFO;
    logic                              empty_instFIFO;
    logic [IW+CID_W:0]                 dout_instFIFO;
    logic [NUM_CORE-1:0]               core_inst_valid;
    logic [NUM_CORE-1:0]               core_inst_ready;
    logic [IW-1:0]                     core_inst_data;
    logic [NUM_CORE-1:0]               core_out_valid;
    logic [NUM_CORE-1:0]               core_out_ready;
    logic [NUM_CORE*DATAOUT_WIDTH-1:0] core_out_data;
    logic                              push_n_oFIFO;
    logic                              full_oFIFO;
    logic [OW-1:0]                     din_oFIFO;

    // Router side
    modport master (
        output pop_n_instFIFO,
        input  empty_instFIFO,
        input  dout_instFIFO,
        output core_inst_valid,
        input  core_inst_ready,
        output core_inst_data,
        input  core_out_valid,
        output core_out_ready,
        input  core_out_data,
        output push_n_oFIFO,
        input  full_oFIFO,
        output din_oFIFO
    );

    // FIFO / core side
    modport slave (
        input  pop_n_instFIFO,
        output empty_instFIFO,
        output dout_instFIFO,
        input  core_inst_valid,
        output core_inst_ready,
        input  core_inst_data,
        output core_out_valid,
        input  core_out_ready,
        output core_out_data,
        input  push_n_oFIFO,
        output full_oFIFO,
        input  din_oFIFO
    );

endinterface

// File: rtl/rram_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N-1.
module rram_rr_arbiter import rram_route_pkg::*; #(
    parameter int unsigned N = 4,
    parameter int unsigned W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_c,
    output logic [W-1:0] gnt_idx_c,
    output logic         gnt_vld_c
);

    int unsigned pos;

    // Scan N positions starting at ptr; the first active request wins
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_vld_c = 1'b0;
        pos       = 32'd0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!gnt_vld_c && req[pos[W-1:0]]) begin
                gnt_vld_c           = 1'b1;
                gnt_c[pos[W-1:0]]   = 1'b1;
                gnt_idx_c           = pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/rram_cluster_router.sv
// Multi-core RRAM router: steers instructions from one shared FIFO to NUM_CORE
// cores (unicast or broadcast) and merges per-core output words round-robin
// into one shared output FIFO.
// Optional feature macro: RRAM_ROUTE_TAG_EN (prefix output words with source cid).
module rram_cluster_router import rram_route_pkg::*; #(
    parameter int unsigned NUM_CORE      = DEF_NUM_CORE,
    parameter int unsigned INSTR_WIDTH   = DEF_INSTR_WIDTH,
    parameter int unsigned OPCODE_WIDTH  = DEF_OPCODE_WIDTH,
    parameter int unsigned DATAOUT_WIDTH = DEF_DATAOUT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  rst,
    rram_cluster_router_if.master bus,
    output logic                  err_bad_cid,
    output logic                  busy
);

    localparam int unsigned CID_W = clog2_min1(NUM_CORE);
    localparam int unsigned IW    = INSTR_WIDTH + OPCODE_WIDTH;
`ifdef RRAM_ROUTE_TAG_EN
    localparam int unsigned OW    = DATAOUT_WIDTH + CID_W;
`else
    localparam int unsigned OW    = DATAOUT_WIDTH;
`endif

    typedef struct packed {
        logic             bcast;
        logic [CID_W-1:0] cid;
        logic [IW-1:0]    body;
    } route_word_t;

    // ---------------- instruction path ----------------
    inst_state_e         state, state_nxt;
    logic [NUM_CORE-1:0] pend_mask, pend_nxt, pend_left;
    logic [IW-1:0]       data_q, data_nxt;
    logic                err_nxt;
    logic                pop;
    route_word_t         head;

    assign head = bus.dout_instFIFO;

    // Next-state: pop when idle or when the last pending core accepts this cycle
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_mask;
        data_nxt  = data_q;
        err_nxt   = 1'b0;
        pop       = 1'b0;
        pend_left = pend_mask & ~bus.core_inst_ready;

        unique case (state)
            IDLE: begin
                pop = ~bus.empty_instFIFO;
            end
            ISSUE: begin
                pend_nxt = pend_left;
                if (pend_left == '0) begin
                    state_nxt = IDLE;
                    pop       = ~bus.empty_instFIFO;
                end
            end
            default: begin
                state_nxt = IDLE;
                pend_nxt  = '0;
            end
        endcase

        if (rst) begin
            pop = 1'b0;
        end

        if (pop) begin
            if (!head.bcast && (32'(head.cid) >= NUM_CORE)) begin
                // Unroutable unicast: consume and flag, never issue
                err_nxt   = 1'b1;
                state_nxt = IDLE;
                pend_nxt  = '0;
            end else begin
                state_nxt = ISSUE;
                pend_nxt  = head.bcast ? '1 : (NUM_CORE'(1) << head.cid);
                data_nxt  = head.body;
            end
        end
    end

    // Instruction FSM state, pending mask, issued instruction and error pulse
    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= IDLE;
            pend_mask   <= '0;
            data_q      <= '0;
            err_bad_cid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend_mask   <= pend_nxt;
            data_q      <= data_nxt;
            err_bad_cid <= err_nxt;
        end
    end

    assign bus.pop_n_instFIFO  = ~pop;
    assign bus.core_inst_valid = pend_mask;
    assign bus.core_inst_data  = data_q;

    // ---------------- output merge ----------------
    logic                     out_vld;
    logic [OW-1:0]            out_q;
    logic [CID_W-1:0]         rr_ptr, rr_nxt;
    logic [NUM_CORE-1:0]      gnt;
    logic [CID_W-1:0]         gnt_idx;
    logic                     gnt_vld;
    logic                     push, slot_free;
    logic [OW-1:0]            out_word;
    logic [DATAOUT_WIDTH-1:0] words [NUM_CORE];

    for (genvar g = 0; g < NUM_CORE; g++) begin : g_unpack
        assign words[g] = bus.core_out_data[g*DATAOUT_WIDTH +: DATAOUT_WIDTH];
    end

    rram_rr_arbiter #(
        .N (NUM_CORE),
        .W (CID_W)
    ) u_arb (
        .req       (bus.core_out_valid),
        .ptr       (rr_ptr),
        .gnt_c     (gnt),
        .gnt_idx_c (gnt_idx),
        .gnt_vld_c (gnt_vld)
    );

    assign push      = out_vld & ~bus.full_oFIFO;
    assign slot_free = ~out_vld | push;

    // Granted word, optionally tagged with its source core
    always_comb begin
`ifdef RRAM_ROUTE_TAG_EN
        out_word = {gnt_idx, words[gnt_idx]};
`else
        out_word = words[gnt_idx];
`endif
        rr_nxt = (32'(gnt_idx) == NUM_CORE - 1) ? '0 : gnt_idx + CID_W'(1);
    end

    // Single-entry output register and round-robin pointer
    always_ff @(posedge CLK) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_q   <= '0;
            rr_ptr  <= '0;
        end else if (slot_free) begin
            if (gnt_vld) begin
                out_vld <= 1'b1;
                out_q   <= out_word;
                rr_ptr  <= rr_nxt;
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

    assign bus.push_n_oFIFO   = ~(push & ~rst);
    assign bus.core_out_ready = (slot_free && !rst) ? gnt : '0;
    assign bus.din_oFIFO      = out_q;
    assign busy               = (state == ISSUE) | out_vld;

endmodule

// File: tb/tb_rram_cluster_router.sv
// Directed bench for rram_cluster_router: a 4-core instance for routing and
// merge, a 3-core instance for bad-cid and non-power-of-two wrap behaviour.
module tb_rram_cluster_router;
    import rram_route_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 2;
`ifdef RRAM_ROUTE_TAG_EN
    localparam int unsigned OW = DW + CW;
`else
    localparam int unsigned OW = DW;
`endif

    logic CLK = 1'b0;
    logic rst;
    logic err4, busy4, err3, busy3;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    rram_cluster_router_if #(.NUM_CORE(4), .INSTR_WIDTH(4), .OPCODE_WIDTH(16), .DATAOUT_WIDTH(DW)) bus4 ();
    rram_cluster_router_if #(.NUM_CORE(3), .INSTR_WIDTH(4), .OPCODE_WIDTH(16), .DATAOUT_WIDTH(DW)) bus3 ();

    rram_cluster_router #(.NUM_CORE(4), .INSTR_WIDTH(4), .OPCODE_WIDTH(16), .DATAOUT_WIDTH(DW)) u4 (
        .CLK(CLK), .rst(rst), .bus(bus4.master), .err_bad_cid(err4), .busy(busy4));
    rram_cluster_router #(.NUM_CORE(3), .INSTR_WIDTH(4), .OPCODE_WIDTH(16), .DATAOUT_WIDTH(DW)) u3 (
        .CLK(CLK), .rst(rst), .bus(bus3.master), .err_bad_cid(err3), .busy(busy3));

    typedef struct {
        logic        empty;
        inst_word_t  word;
        logic [3:0]  ready;
        logic        exp_pop_n;
        logic [3:0]  exp_valid;
        logic [19:0] exp_data;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic inst_word_t mkw(input bit b, input int c, input int i, input int op);
        inst_word_t w;
        w.bcast  = b;
        w.cid    = 2'(c);
        w.instr  = 4'(i);
        w.opcode = 16'(op);
        return w;
    endfunction

    function automatic vec_t v(input logic e, input inst_word_t w, input logic [3:0] r,
                               input logic pn, input logic [3:0] val, input logic [19:0] d);
        vec_t x;
        x.empty = e; x.word = w; x.ready = r;
        x.exp_pop_n = pn; x.exp_valid = val; x.exp_data = d;
        return x;
    endfunction

    function automatic logic [DW-1:0] word_of(input int c);
        return 64'hC0DE_5EED_0000_0000 | 64'(c * 17 + 1);
    endfunction

    function automatic logic [OW-1:0] expw(input int c);
`ifdef RRAM_ROUTE_TAG_EN
        return {CW'(c), word_of(c)};
`else
        return word_of(c);
`endif
    endfunction

    initial begin
        inst_word_t z;
        int exp_seq [3];
        z = '0;

        // Instruction path vectors: one row per cycle, outputs checked before the edge
        vecs[0]  = v(1, z,                     4'b0000, 1, 4'b0000, 20'h00000);
        vecs[1]  = v(0, mkw(0,2,3,'h1234),     4'b1111, 0, 4'b0000, 20'h00000);
        vecs[2]  = v(1, z,                     4'b1111, 1, 4'b0100, 20'h31234);
        vecs[3]  = v(1, z,                     4'b1111, 1, 4'b0000, 20'h31234);
        vecs[4]  = v(0, mkw(0,1,5,'hAAAA),     4'b1111, 0, 4'b0000, 20'h31234);
        vecs[5]  = v(0, mkw(0,3,6,'hBBBB),     4'b1111, 0, 4'b0010, 20'h5AAAA);
        vecs[6]  = v(0, mkw(0,0,7,'hCCCC),     4'b1111, 0, 4'b1000, 20'h6BBBB);
        vecs[7]  = v(1, z,                     4'b0000, 1, 4'b0001, 20'h7CCCC);
        vecs[8]  = v(1, z,                     4'b0001, 1, 4'b0001, 20'h7CCCC);
        vecs[9]  = v(0, mkw(1,0,9,'h1357),     4'b0000, 0, 4'b0000, 20'h7CCCC);
        vecs[10] = v(0, mkw(0,2,4,'h2468),     4'b0001, 1, 4'b1111, 20'h91357);
        vecs[11] = v(0, mkw(0,2,4,'h2468),     4'b1000, 1, 4'b1110, 20'h91357);
        vecs[12] = v(0, mkw(0,2,4,'h2468),     4'b0000, 1, 4'b0110, 20'h91357);
        vecs[13] = v(0, mkw(0,2,4,'h2468),     4'b0000, 1, 4'b0110, 20'h91357);
        vecs[14] = v(0, mkw(0,2,4,'h2468),     4'b0110, 0, 4'b0110, 20'h91357);
        vecs[15] = v(1, z,                     4'b0000, 1, 4'b0100, 20'h42468);
        vecs[16] = v(1, z,                     4'b0100, 1, 4'b0100, 20'h42468);
        vecs[17] = v(1, z,                     4'b0000, 1, 4'b0000, 20'h42468);

        // Reset with every input active: combinational outputs must stay quiet
        rst = 1'b1;
        bus4.empty_instFIFO = 1'b0; bus4.dout_instFIFO = '0; bus4.core_inst_ready = '0;
        bus4.core_out_valid = '1;   bus4.full_oFIFO = 1'b0;
        bus3.empty_instFIFO = 1'b0; bus3.dout_instFIFO = '0; bus3.core_inst_ready = '0;
        bus3.core_out_valid = '1;   bus3.full_oFIFO = 1'b0;
        for (int i = 0; i < 4; i++) bus4.core_out_data[i*DW +: DW] = word_of(i);
        for (int i = 0; i < 3; i++) bus3.core_out_data[i*DW +: DW] = word_of(i);

        @(negedge CLK); #1;
        check("rst_pop_n",     128'(bus4.pop_n_instFIFO), 128'(1));
        check("rst_push_n",    128'(bus4.push_n_oFIFO),   128'(1));
        check("rst_out_ready", 128'(bus4.core_out_ready), 128'(0));
        @(negedge CLK); #1;
        check("rst_inst_valid", 128'(bus4.core_inst_valid), 128'(0));
        check("rst_inst_data",  128'(bus4.core_inst_data),  128'(0));
        check("rst_din",        128'(bus4.din_oFIFO),       128'(0));
        check("rst_err",        128'(err4),                 128'(0));
        check("rst_busy",       128'(busy4),                128'(0));
        check("rst3_out_ready", 128'(bus3.core_out_ready),  128'(0));
        bus4.empty_instFIFO = 1'b1; bus4.core_out_valid = '0;
        bus3.empty_instFIFO = 1'b1; bus3.core_out_valid = '0;
        rst = 1'b0;

        // Unicast, sustained unicast, broadcast with staggered accepts
        for (int k = 0; k < 18; k++) begin
            @(negedge CLK);
            bus4.empty_instFIFO  = vecs[k].empty;
            bus4.dout_instFIFO   = vecs[k].word;
            bus4.core_inst_ready = vecs[k].ready;
            #1;
            check($sformatf("vec%0d_pop_n", k), 128'(bus4.pop_n_instFIFO),  128'(vecs[k].exp_pop_n));
            check($sformatf("vec%0d_valid", k), 128'(bus4.core_inst_valid), 128'(vecs[k].exp_valid));
            check($sformatf("vec%0d_data", k),  128'(bus4.core_inst_data),  128'(vecs[k].exp_data));
            check($sformatf("vec%0d_busy", k),  128'(busy4),                128'(|vecs[k].exp_valid));
            check($sformatf("vec%0d_err", k),   128'(err4),                 128'(0));
        end

        // Round-robin with all four cores valid: 0,1,2,3,0,1,2,3, one push per cycle
        @(negedge CLK);
        bus4.core_out_valid = 4'b1111;
        #1;
        check("rr_first_push_n", 128'(bus4.push_n_oFIFO),   128'(1));
        check("rr_first_ready",  128'(bus4.core_out_ready), 128'(4'b0001));
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK); #1;
            check($sformatf("rr%0d_push_n", k), 128'(bus4.push_n_oFIFO), 128'(0));
            check($sformatf("rr%0d_din", k),    128'(bus4.din_oFIFO),    128'(expw(k % 4)));
            if (k == 7) bus4.core_out_valid = '0;
        end
        @(negedge CLK); #1;
        check("rr_drained_push_n", 128'(bus4.push_n_oFIFO), 128'(1));

        // Backpressure: full for 5 cycles with a word held
        bus4.full_oFIFO = 1'b1; bus4.core_out_valid = 4'b1111;
        #1;
        check("bp_load_ready", 128'(bus4.core_out_ready), 128'(4'b0001));
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK); #1;
            check($sformatf("bp%0d_push_n", k), 128'(bus4.push_n_oFIFO),   128'(1));
            check($sformatf("bp%0d_din", k),    128'(bus4.din_oFIFO),      128'(expw(0)));
            check($sformatf("bp%0d_ready", k),  128'(bus4.core_out_ready), 128'(0));
        end
        bus4.full_oFIFO = 1'b0;
        #1;
        check("bp_resume_push_n", 128'(bus4.push_n_oFIFO),   128'(0));
        check("bp_resume_ready",  128'(bus4.core_out_ready), 128'(4'b0010));
        check("bp_resume_din",    128'(bus4.din_oFIFO),      128'(expw(0)));
        @(negedge CLK); #1;
        check("bp_next_din", 128'(bus4.din_oFIFO),   128'(expw(1)));
        check("bp_next_push_n", 128'(bus4.push_n_oFIFO), 128'(0));
        bus4.core_out_valid = '0;
        @(negedge CLK); #1;
        check("bp_drained_push_n", 128'(bus4.push_n_oFIFO), 128'(1));

        // Sparse requesters from pointer 2: cores 3,0,3
        bus4.core_out_valid = 4'b1001;
        #1;
        check("sparse_ready", 128'(bus4.core_out_ready), 128'(4'b1000));
        exp_seq[0] = 3; exp_seq[1] = 0; exp_seq[2] = 3;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); #1;
            check($sformatf("sparse%0d_din", k),    128'(bus4.din_oFIFO),    128'(expw(exp_seq[k])));
            check($sformatf("sparse%0d_push_n", k), 128'(bus4.push_n_oFIFO), 128'(0));
        end
        bus4.core_out_valid = '0;
        @(negedge CLK); #1;
        check("sparse_drained_push_n", 128'(bus4.push_n_oFIFO), 128'(1));

        // Reset in the middle of a broadcast with pend_mask = 1010 and a held output word
        bus4.empty_instFIFO = 1'b0; bus4.dout_instFIFO = mkw(1,0,10,'hF00D); bus4.core_inst_ready = '0;
        @(negedge CLK);
        bus4.empty_instFIFO = 1'b1; bus4.core_inst_ready = 4'b0101;
        bus4.full_oFIFO = 1'b1; bus4.core_out_valid = 4'b1111;
        #1;
        check("mid_bcast_valid", 128'(bus4.core_inst_valid), 128'(4'b1111));
        @(negedge CLK);
        bus4.core_inst_ready = '0;
        #1;
        check("mid_pend_1010", 128'(bus4.core_inst_valid), 128'(4'b1010));
        check("mid_held_din",  128'(bus4.din_oFIFO),       128'(expw(0)));
        check("mid_full_push", 128'(bus4.push_n_oFIFO),    128'(1));
        check("mid_busy",      128'(busy4),                128'(1));
        rst = 1'b1; bus4.empty_instFIFO = 1'b0; bus4.full_oFIFO = 1'b0;
        #1;
        check("mid_rst_pop_n",  128'(bus4.pop_n_instFIFO), 128'(1));
        check("mid_rst_push_n", 128'(bus4.push_n_oFIFO),   128'(1));
        check("mid_rst_ready",  128'(bus4.core_out_ready), 128'(0));
        @(negedge CLK); #1;
        check("post_rst_valid", 128'(bus4.core_inst_valid), 128'(0));
        check("post_rst_busy",  128'(busy4),                128'(0));
        check("post_rst_din",   128'(bus4.din_oFIFO),       128'(0));
        rst = 1'b0; bus4.empty_instFIFO = 1'b1; bus4.core_out_valid = '0;
        @(negedge CLK); #1;
        check("no_replay_push_n", 128'(bus4.push_n_oFIFO),   128'(1));
        check("no_replay_valid",  128'(bus4.core_inst_valid), 128'(0));

        // 3-core instance: unicast to cid 3 is dropped with a one-cycle error pulse
        bus3.empty_instFIFO = 1'b0; bus3.dout_instFIFO = mkw(0,3,2,'h0BAD); bus3.core_inst_ready = 3'b111;
        #1;
        check("bad_pop_n", 128'(bus3.pop_n_instFIFO), 128'(0));
        @(negedge CLK);
        bus3.empty_instFIFO = 1'b1;
        #1;
        check("bad_err",   128'(err3),                 128'(1));
        check("bad_valid", 128'(bus3.core_inst_valid), 128'(0));
        check("bad_busy",  128'(busy3),                128'(0));
        @(negedge CLK); #1;
        check("bad_err_clear", 128'(err3), 128'(0));
        bus3.empty_instFIFO = 1'b0; bus3.dout_instFIFO = mkw(1,1,8,'h4321); bus3.core_inst_ready = '0;
        @(negedge CLK);
        bus3.empty_instFIFO = 1'b1;
        #1;
        check("bcast3_valid", 128'(bus3.core_inst_valid), 128'(3'b111));
        check("bcast3_data",  128'(bus3.core_inst_data),  128'(20'h84321));
        bus3.core_inst_ready = 3'b111;
        @(negedge CLK); #1;
        check("bcast3_done", 128'(bus3.core_inst_valid), 128'(0));

        // 3-core round-robin wraps 2 -> 0
        bus3.core_out_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK); #1;
            check($sformatf("rr3_%0d_din", k),    128'(bus3.din_oFIFO),    128'(expw(k % 3)));
            check($sformatf("rr3_%0d_push_n", k), 128'(bus3.push_n_oFIFO), 128'(0));
        end
        bus3.core_out_valid = '0;
        @(negedge CLK); @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
